// File: rtl/uart_frame_parser.sv
// Turns a UART byte stream into checksum-validated command frames held for a consumer.
// Reports checksum, length and inter-byte timeout errors, and counts bytes dropped while a frame is held.
module uart_frame_parser #(
    parameter logic [7:0] HEADER         = 8'hAA,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100_000,
    parameter int         AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    output logic          frame_valid,
    output logic [7:0]    frame_cmd,
    output logic [7:0]    frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          err_pulse,
    output logic [1:0]    err_code,
    output logic [7:0]    drop_cnt
);
    localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     LEN_MAX  = 8'(MAX_LEN);
    localparam logic [1:0]     ERR_SUM  = 2'd1;
    localparam logic [1:0]     ERR_LEN  = 2'd2;
    localparam logic [1:0]     ERR_TMO  = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t        state_q;
    logic [7:0]    sum_q;
    logic [AW-1:0] idx_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    buf_q [MAX_LEN];
    logic          frame_valid_q;
    logic [7:0]    frame_cmd_q;
    logic [7:0]    frame_len_q;
    logic          err_pulse_q;
    logic [1:0]    err_code_q;
    logic [7:0]    drop_cnt_q;
    logic          tmo_active_s;
    logic          tmo_expired_s;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // Timer only runs while a frame is partially received
    always_comb begin
        tmo_active_s = 1'b0;
        case (state_q)
            S_CMD, S_LEN, S_PAYLOAD, S_CHECK: tmo_active_s = 1'b1;
            default:                          tmo_active_s = 1'b0;
        endcase
    end

    // A byte arriving on the expiry cycle takes precedence over the timeout
    assign tmo_expired_s = tmo_active_s && !rx_done && (tmo_cnt_q == TMO_LAST);

    // Payload read port, zero beyond the held length
    always_comb begin
        rd_data = 8'h00;
        if (9'(rd_addr) < 9'(frame_len_q)) begin
            rd_data = buf_q[rd_addr];
        end else begin
            rd_data = 8'h00;
        end
    end

    // Parser state machine, inter-byte timer, payload buffer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_HUNT;
            sum_q         <= 8'h00;
            idx_q         <= '0;
            tmo_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_cmd_q   <= 8'h00;
            frame_len_q   <= 8'h00;
            err_pulse_q   <= 1'b0;
            err_code_q    <= 2'd0;
            drop_cnt_q    <= 8'h00;
        end else begin
            err_pulse_q <= 1'b0;
            if (rx_done || !tmo_active_s) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end

            case (state_q)
                S_HUNT: begin
                    if (rx_done && (rx_data == HEADER)) begin
                        sum_q   <= 8'h00;
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (rx_done) begin
                        frame_cmd_q <= rx_data;
                        sum_q       <= csum_add(sum_q, rx_data);
                        state_q     <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_done) begin
                        if (rx_data > LEN_MAX) begin
                            err_pulse_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= S_HUNT;
                        end else begin
                            frame_len_q <= rx_data;
                            sum_q       <= csum_add(sum_q, rx_data);
                            idx_q       <= '0;
                            state_q     <= (rx_data == 8'h00) ? S_CHECK : S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_done) begin
                        buf_q[idx_q] <= rx_data;
                        sum_q        <= csum_add(sum_q, rx_data);
                        idx_q        <= idx_q + AW'(1);
                        if ((9'(idx_q) + 9'd1) == 9'(frame_len_q)) begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (rx_done) begin
                        if (rx_data == sum_q) begin
                            frame_valid_q <= 1'b1;
                            state_q       <= S_HOLD;
                        end else begin
                            err_pulse_q <= 1'b1;
                            err_code_q  <= ERR_SUM;
                            state_q     <= S_HUNT;
                        end
                    end
                end
                S_HOLD: begin
                    // Bytes arriving while held are lost, even alongside the ack
                    if (rx_done && (drop_cnt_q != 8'hFF)) begin
                        drop_cnt_q <= drop_cnt_q + 8'd1;
                    end
                    if (frame_ack) begin
                        frame_valid_q <= 1'b0;
                        state_q       <= S_HUNT;
                    end
                end
                default: state_q <= S_HUNT;
            endcase

            if (tmo_expired_s) begin
                err_pulse_q <= 1'b1;
                err_code_q  <= ERR_TMO;
                state_q     <= S_HUNT;
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_len   = frame_len_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and randomized checks of uart_frame_parser against a frame-level reference model.
module tb_uart_frame_parser;
    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 40;
    localparam int         AW      = 4;
    localparam logic [7:0] HDR     = 8'hAA;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          frame_valid;
    logic [7:0]    frame_cmd;
    logic [7:0]    frame_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_ack;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic [7:0]    drop_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model of what the consumer should observe
    logic       m_valid;
    logic [7:0] m_cmd;
    logic [7:0] m_len;
    logic [7:0] m_pl [MAX_LEN];
    logic       m_ep;
    logic [1:0] m_ec;
    int         m_drop;

    always #50 clk = ~clk;

    uart_frame_parser #(
        .HEADER(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_ack(frame_ack),
        .err_pulse(err_pulse), .err_code(err_code), .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(frame_valid), 32'(m_valid));
        check({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_ep));
        check({tag, ".err_code"}, 32'(err_code), 32'(m_ec));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        check({tag, ".exclusive"}, 32'(frame_valid & err_pulse), 32'd0);
        if (m_valid) begin
            check({tag, ".cmd"}, 32'(frame_cmd), 32'(m_cmd));
            check({tag, ".len"}, 32'(frame_len), 32'(m_len));
            for (int i = 0; i < (1 << AW); i++) begin
                rd_addr = AW'(i);
                #1;
                check({tag, ".rd_data"}, 32'(rd_data),
                      32'((i < int'(m_len)) ? m_pl[i] : 8'h00));
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_cmd = 8'h00; m_len = 8'h00;
        m_ep = 1'b0; m_ec = 2'd0; m_drop = 0;
        for (int i = 0; i < MAX_LEN; i++) m_pl[i] = 8'h00;
    endtask

    task automatic check_reset(input string tag);
        check_model(tag);
        check({tag, ".cmd0"}, 32'(frame_cmd), 32'd0);
        check({tag, ".len0"}, 32'(frame_len), 32'd0);
        rd_addr = AW'(0);
        #1 check({tag, ".rd0"}, 32'(rd_data), 32'd0);
        rd_addr = AW'(15);
        #1 check({tag, ".rd15"}, 32'(rd_data), 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int max_gap);
        idle(int'($urandom_range(0, max_gap)));
    endtask

    task automatic drop_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            send(8'($urandom));
            m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
        end
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        m_valid = 1'b0;
        check_model(tag);
    endtask

    task automatic error_seen(input string tag, input logic [1:0] code);
        m_valid = 1'b0; m_ep = 1'b1; m_ec = code;
        check_model(tag);
        @(negedge clk);
        m_ep = 1'b0;
        check_model({tag, ".next"});
    endtask

    // Sends one frame; the expected outcome follows from the length limit and the byte sum
    task automatic run_frame(input logic [7:0] cmd, input int len, input bit bad_sum, input int max_gap);
        logic [7:0] pl [MAX_LEN];
        logic [7:0] sum;
        send(HDR); gap(max_gap);
        send(cmd); gap(max_gap);
        send(8'(len));
        if (len > MAX_LEN) begin
            error_seen("len_err", 2'd2);
        end else begin
            sum = cmd + 8'(len);
            for (int i = 0; i < len; i++) begin
                gap(max_gap);
                pl[i] = 8'($urandom);
                sum = sum + pl[i];
                send(pl[i]);
            end
            gap(max_gap);
            check_model("pre_sum");
            if (bad_sum) begin
                send(sum + 8'($urandom_range(1, 255)));
                error_seen("sum_err", 2'd1);
            end else begin
                send(sum);
                m_valid = 1'b1; m_cmd = cmd; m_len = 8'(len);
                for (int i = 0; i < MAX_LEN; i++) m_pl[i] = (i < len) ? pl[i] : 8'h00;
                check_model("frame");
            end
        end
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; frame_ack = 1'b0; rd_addr = '0;
        model_reset();
        idle(3);
        rst = 1'b0;
        check_reset("reset");

        // Known good frame and its release
        send(8'hAA); send(8'h01); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
        check_model("good_pre");
        send(8'h64);
        m_valid = 1'b1; m_cmd = 8'h01; m_len = 8'h03;
        m_pl[0] = 8'h10; m_pl[1] = 8'h20; m_pl[2] = 8'h30;
        check_model("good");
        ack("good_ack");

        send(8'hAA); send(8'h01); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
        send(8'h65);
        error_seen("bad_sum", 2'd1);
        run_frame(8'($urandom), 3, 1'b0, 2);
        ack("after_bad_ack");

        // Header noise, length error, then a zero-length frame
        send(8'h55); send(8'hAA); send(8'h02); send(8'h11);
        error_seen("len17", 2'd2);
        send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
        m_valid = 1'b1; m_cmd = 8'h05; m_len = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) m_pl[i] = 8'h00;
        check_model("len0");
        ack("len0_ack");

        // A byte shortly before expiry restarts the timer; silence then times out in CHECK
        send(8'hAA); send(8'h01);
        idle(TMO - 3);
        send(8'h00);
        check_model("tmo_restart");
        idle(TMO - 1);
        check_model("tmo_restart_quiet");
        @(negedge clk);
        error_seen("tmo_check", 2'd3);

        send(8'hAA); send(8'h01);
        idle(TMO - 1);
        check_model("tmo_pre");
        @(negedge clk);
        error_seen("tmo_len", 2'd3);

        // Byte on the expiry cycle wins over the timeout
        send(8'hAA);
        idle(TMO - 2);
        send(8'h07);
        check_model("tmo_race");
        send(8'h00); send(8'h07);
        m_valid = 1'b1; m_cmd = 8'h07; m_len = 8'h00;
        check_model("tmo_race_frame");
        ack("tmo_race_ack");

        // Overrun while held, then ack coinciding with a header byte
        run_frame(8'($urandom), int'($urandom_range(1, MAX_LEN)), 1'b0, 1);
        drop_bytes(3);
        check_model("overrun");
        @(negedge clk);
        rx_data = HDR; rx_done = 1'b1; frame_ack = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; frame_ack = 1'b0;
        m_valid = 1'b0;
        m_drop = m_drop + 1;
        check_model("ack_with_hdr");
        send(8'h01); send(8'h00); send(8'h01);
        check_model("no_frame_started");

        // Reset in the middle of a frame
        send(8'hAA); send(8'h01); send(8'h03); send(8'h10);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        check_reset("mid_reset");
        run_frame(8'h01, 3, 1'b0, 0);
        ack("post_reset_ack");

        // Drop counter saturation
        run_frame(8'($urandom), MAX_LEN, 1'b0, 0);
        drop_bytes(260);
        check_model("drop_sat");
        ack("drop_sat_ack");

        // Randomized frames with noise, gaps, errors and drops
        for (int it = 0; it < 40; it++) begin
            int         nz;
            int         kind;
            logic [7:0] nb;
            nz = int'($urandom_range(0, 2));
            for (int k = 0; k < nz; k++) begin
                do nb = 8'($urandom); while (nb == HDR);
                send(nb);
            end
            kind = int'($urandom_range(0, 5));
            if (kind == 5) begin
                run_frame(8'($urandom), int'($urandom_range(MAX_LEN + 1, 255)), 1'b0, 3);
            end else begin
                run_frame(8'($urandom), int'($urandom_range(0, MAX_LEN)), kind == 4, 3);
                if (kind != 4) begin
                    drop_bytes(int'($urandom_range(0, 2)));
                    check_model("rand_hold");
                    ack("rand_ack");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
